// File: rtl/image_read_stream.sv
// Frame source: streams a stored RGB888 frame from a sync-read RAM as HSYNC-qualified pixel pairs with VSYNC/blanking.
// Optional build macro IMG_READ_TESTPAT_EN adds test_mode, which replaces RAM reads with an 8-bar colour pattern.
module image_read_stream #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int ADDR_W         = 18,
    parameter int VSYNC_CYCLES   = 2,
    parameter int START_UP_DELAY = 100,
    parameter int HSYNC_DELAY    = 160
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
`ifdef IMG_READ_TESTPAT_EN
    input  logic              test_mode,
`endif
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [47:0]       mem_rdata,
    output logic              VSYNC,
    output logic              HSYNC,
    output logic [7:0]        DATA_R0,
    output logic [7:0]        DATA_G0,
    output logic [7:0]        DATA_B0,
    output logic [7:0]        DATA_R1,
    output logic [7:0]        DATA_G1,
    output logic [7:0]        DATA_B1,
    output logic              busy,
    output logic              frame_done
);

    localparam int HALF  = WIDTH / 2;
    localparam int MAXD0 = (VSYNC_CYCLES > START_UP_DELAY) ? VSYNC_CYCLES : START_UP_DELAY;
    localparam int MAXD  = (MAXD0 > HSYNC_DELAY) ? MAXD0 : HSYNC_DELAY;
    localparam int CNT_W = $clog2(MAXD + 2);
    localparam int M_W   = $clog2(HALF + 1);
    localparam int L_W   = $clog2(HEIGHT + 1);

    localparam logic [CNT_W-1:0]  VS_LAST  = (VSYNC_CYCLES   < 1) ? '0 : CNT_W'(VSYNC_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SU_LAST  = (START_UP_DELAY < 1) ? '0 : CNT_W'(START_UP_DELAY - 1);
    localparam logic [CNT_W-1:0]  HB_LAST  = (HSYNC_DELAY    < 1) ? '0 : CNT_W'(HSYNC_DELAY - 1);
    localparam logic [M_W-1:0]    M_LAST   = M_W'(HALF - 1);
    localparam logic [L_W-1:0]    L_LAST   = L_W'(HEIGHT - 1);
    // Rows are stored bottom-up, so the first line read is the last row in RAM.
    localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'((HEIGHT - 1) * HALF);
    localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(HALF);

    typedef enum logic [2:0] {
        S_IDLE, S_VSYNC, S_STARTUP, S_ACTIVE, S_HBLANK, S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [M_W-1:0]     r_m;
    logic [L_W-1:0]     r_l;
    logic [ADDR_W-1:0]  r_base;
    logic               r_hsync;
    logic               r_frame_done;
    logic               w_line_end;
    logic               w_ram_sel;

    assign w_line_end = (r_m == M_LAST);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_VSYNC;
            S_VSYNC:   if (r_cnt == VS_LAST)
                           w_next = (START_UP_DELAY == 0) ? S_ACTIVE : S_STARTUP;
            S_STARTUP: if (r_cnt == SU_LAST) w_next = S_ACTIVE;
            S_ACTIVE:  if (w_line_end) begin
                           if (r_l == L_LAST)        w_next = S_DONE;
                           else if (HSYNC_DELAY == 0) w_next = S_ACTIVE;
                           else                       w_next = S_HBLANK;
                       end
            S_HBLANK:  if (r_cnt == HB_LAST) w_next = S_ACTIVE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != S_IDLE);
        VSYNC    = (r_state == S_VSYNC);
        mem_en   = (r_state == S_ACTIVE) && w_ram_sel;
        mem_addr = mem_en ? (r_base + ADDR_W'(r_m)) : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt        <= '0;
            r_m          <= '0;
            r_l          <= '0;
            r_base       <= '0;
            r_hsync      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_hsync      <= (r_state == S_ACTIVE);
            r_frame_done <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    r_m    <= '0;
                    r_l    <= '0;
                    r_base <= TOP_BASE;
                end
                S_ACTIVE: begin
                    r_m <= w_line_end ? '0 : r_m + M_W'(1);
                    if (w_line_end && (r_l != L_LAST)) begin
                        r_l    <= r_l + L_W'(1);
                        r_base <= r_base - HALF_A;
                    end
                end
                default: ;
            endcase
        end
    end

    assign HSYNC      = r_hsync;
    assign frame_done = r_frame_done;

`ifdef IMG_READ_TESTPAT_EN
    localparam int BAR_W = (WIDTH / 8 < 1) ? 1 : WIDTH / 8;

    logic       r_test_mode;
    logic [2:0] r_pat0;
    logic [2:0] r_pat1;

    // Pattern is registered in the read cycle so it lines up with HSYNC like RAM data does.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_test_mode <= 1'b0;
            r_pat0      <= '0;
            r_pat1      <= '0;
        end else begin
            if (r_state == S_IDLE && start) r_test_mode <= test_mode;
            if (r_state == S_ACTIVE) begin
                r_pat0 <= 3'({r_m, 1'b0} / BAR_W);
                r_pat1 <= 3'({r_m, 1'b1} / BAR_W);
            end
        end
    end

    assign w_ram_sel = !r_test_mode;
    assign DATA_R0 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat0[0]}} : mem_rdata[23:16];
    assign DATA_G0 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat0[1]}} : mem_rdata[15:8];
    assign DATA_B0 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat0[2]}} : mem_rdata[7:0];
    assign DATA_R1 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat1[0]}} : mem_rdata[47:40];
    assign DATA_G1 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat1[1]}} : mem_rdata[39:32];
    assign DATA_B1 = !r_hsync ? 8'd0 : r_test_mode ? {8{r_pat1[2]}} : mem_rdata[31:24];
`else
    assign w_ram_sel = 1'b1;
    assign DATA_R0 = r_hsync ? mem_rdata[23:16] : 8'd0;
    assign DATA_G0 = r_hsync ? mem_rdata[15:8]  : 8'd0;
    assign DATA_B0 = r_hsync ? mem_rdata[7:0]   : 8'd0;
    assign DATA_R1 = r_hsync ? mem_rdata[47:40] : 8'd0;
    assign DATA_G1 = r_hsync ? mem_rdata[39:32] : 8'd0;
    assign DATA_B1 = r_hsync ? mem_rdata[31:24] : 8'd0;
`endif

endmodule
